mmc_spi_slave: RTL



---
 rtl/mmc_spi_pkg.sv | 17 +
 rtl/spi_pin_sync.sv | 30 +++
 rtl/mmc_spi_slave.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mmc_spi_pkg.sv
// Shared definitions for the MMC mailbox SPI slave: frame geometry and FSM encoding.
package mmc_spi_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_BITS  = 8;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_WAIT_CS = 3'd4
  } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin with registered edge events.
module spi_pin_sync #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sh;

  // Edge events come from the two oldest stages; o_level matches the event cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh   <= '0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_sh   <= {r_sh[STAGES-2:0], i_pin};
      o_rise <= r_sh[STAGES-2] & ~r_sh[STAGES-1];
      o_fall <= ~r_sh[STAGES-2] & r_sh[STAGES-1];
    end
  end

  assign o_level = r_sh[STAGES-1];

endmodule

// File: rtl/mmc_spi_slave.sv
// SPI mode-0 slave: turns 16-bit addr/data frames into clk-domain mailbox strobes
// and shifts mailbox read data back on MISO during the data byte.
module mmc_spi_slave
  import mmc_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned RD_DELAY    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SCLK,
  input  logic                 CSB,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_BITS-1:0] config_a,
  output logic [DATA_BITS-1:0] config_d,
  output logic                 config_r,
  output logic                 config_w,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 frame_err,
  output logic [3:0]           spi_pins_debug
);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_csb_lvl, w_csb_rise, w_csb_fall;
  logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_pin(SCLK),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_csb (
    .clk(clk), .rst(rst), .i_pin(CSB),
    .o_level(w_csb_lvl), .o_rise(w_csb_rise), .o_fall(w_csb_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_pin(MOSI),
    .o_level(w_mosi_lvl), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused = &{1'b0, w_mosi_rise, w_mosi_fall};

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [ADDR_BITS-1:0] r_addr_sh;
  logic [DATA_BITS-1:0] r_data_sh;
  logic [DATA_BITS-1:0] r_miso_sh;
  logic                 r_miso_loaded;
  logic                 r_w_pend;
  logic [RD_DELAY-1:0]  r_rd_pipe;

  logic w_last_addr_bit, w_last_bit;
  logic w_clr_cnt, w_shift_a, w_shift_d, w_load_a, w_load_d;
  logic w_miso_load, w_miso_shift, w_miso_clr, w_abort;

  assign w_last_addr_bit = (r_bit_cnt == CNT_W'(ADDR_BITS - 1));
  assign w_last_bit      = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_WAIT_CS;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_csb_fall) w_state_nxt = ST_ADDR;
      ST_ADDR: begin
        if (w_csb_rise)                           w_state_nxt = ST_IDLE;
        else if (w_sclk_rise && w_last_addr_bit) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_csb_rise)                      w_state_nxt = ST_IDLE;
        else if (w_sclk_rise && w_last_bit) w_state_nxt = ST_HOLD;
      end
      ST_HOLD:    if (w_csb_rise) w_state_nxt = ST_IDLE;
      ST_WAIT_CS: if (w_csb_rise) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath controls; MISO is forced low everywhere outside the data byte.
  always_comb begin
    w_clr_cnt    = 1'b0;
    w_shift_a    = 1'b0;
    w_shift_d    = 1'b0;
    w_load_a     = 1'b0;
    w_load_d     = 1'b0;
    w_miso_load  = 1'b0;
    w_miso_shift = 1'b0;
    w_miso_clr   = 1'b1;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: w_clr_cnt = w_csb_fall;
      ST_ADDR: begin
        if (w_csb_rise) begin
          w_abort = 1'b1;
        end else if (w_sclk_rise) begin
          w_shift_a = 1'b1;
          w_load_a  = w_last_addr_bit;
        end
      end
      ST_DATA: begin
        w_miso_clr = 1'b0;
        if (w_csb_rise) begin
          w_abort    = 1'b1;
          w_miso_clr = 1'b1;
        end else begin
          if (w_sclk_rise) begin
            w_shift_d  = 1'b1;
            w_load_d   = w_last_bit;
            w_miso_clr = w_last_bit;
          end
          if (w_sclk_fall) begin
            w_miso_load  = ~r_miso_loaded;
            w_miso_shift = r_miso_loaded;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt     <= '0;
      r_addr_sh     <= '0;
      r_data_sh     <= '0;
      r_miso_sh     <= '0;
      r_miso_loaded <= 1'b0;
      r_w_pend      <= 1'b0;
      r_rd_pipe     <= '0;
      MISO          <= 1'b0;
      config_a      <= '0;
      config_d      <= '0;
      config_r      <= 1'b0;
      config_w      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      if (w_clr_cnt)                   r_bit_cnt <= '0;
      else if (w_shift_a || w_shift_d) r_bit_cnt <= r_bit_cnt + CNT_W'(1);

      if (w_shift_a) r_addr_sh <= {r_addr_sh[ADDR_BITS-2:0], w_mosi_lvl};
      if (w_load_a)  config_a  <= {r_addr_sh[ADDR_BITS-2:0], w_mosi_lvl};
      if (w_shift_d) r_data_sh <= {r_data_sh[DATA_BITS-2:0], w_mosi_lvl};
      if (w_load_d)  config_d  <= {r_data_sh[DATA_BITS-2:0], w_mosi_lvl};

      // Write strobe trails the data load by one cycle; read strobe trails the address by RD_DELAY.
      r_w_pend  <= w_load_d;
      config_w  <= r_w_pend;
      r_rd_pipe <= {r_rd_pipe[RD_DELAY-2:0], w_load_a};
      config_r  <= r_rd_pipe[RD_DELAY-1];
      frame_err <= w_abort;

      if (w_clr_cnt) r_miso_loaded <= 1'b0;
      if (w_miso_clr) begin
        MISO <= 1'b0;
      end else if (w_miso_load) begin
        MISO          <= tx_data[DATA_BITS-1];
        r_miso_sh     <= {tx_data[DATA_BITS-2:0], 1'b0};
        r_miso_loaded <= 1'b1;
      end else if (w_miso_shift) begin
        MISO      <= r_miso_sh[DATA_BITS-1];
        r_miso_sh <= {r_miso_sh[DATA_BITS-2:0], 1'b0};
      end
    end
  end

  assign spi_pins_debug = {MISO, w_mosi_lvl, w_csb_lvl, w_sclk_lvl};

endmodule
